axi_mem_master: RTL and testbench

AXI4 master that turns the CPU's single-word memory port (oe/addr/wdata/we in, rdata/valid/busy out) into single-beat 128-bit AXI4 transactions for the MIG DDR2 block. It is the initiator for the MIG's S_AXI slave port and sits between the CPU data-memory path and the DRAM controller. Only one transaction is in flight at a time. An optional one-line read buffer serves repeat reads to the same 16-byte line without AXI traffic.

---
 rtl/axi_mem_master.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_axi_mem_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_master.sv
// axi_mem_master: bridges the CPU single-word data-memory port onto single-beat
// 128-bit AXI4 transactions for the MIG DDR2 S_AXI port. One transaction is in
// flight at a time; requests seen while busy are dropped.
// Optional feature macro: AXI_MEM_RDBUF_EN adds a one-line read buffer that
// serves repeat reads of the same 16-byte line without any AXI traffic.
module axi_mem_master #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // CPU side
  input  logic              dram_oe,
  input  logic [ADDR_W-1:0] dram_addr,
  input  logic [31:0]       dram_wdata,
  input  logic [3:0]        dram_we,
  output logic [31:0]       dram_rdata,
  output logic              dram_valid,
  output logic              dram_busy,
  output logic              resp_err,
  // AXI write address channel
  output logic [0:0]        m_axi_awid,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awlock,
  output logic [3:0]        m_axi_awcache,
  output logic [2:0]        m_axi_awprot,
  output logic [3:0]        m_axi_awqos,
  output logic [3:0]        m_axi_awregion,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  // AXI write data channel
  output logic [127:0]      m_axi_wdata,
  output logic [15:0]       m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  // AXI write response channel
  input  logic [0:0]        m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  // AXI read address channel
  output logic [0:0]        m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arqos,
  output logic [3:0]        m_axi_arregion,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  // AXI read data channel
  input  logic [0:0]        m_axi_rid,
  input  logic [127:0]      m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WRESP,
    S_RD_AR,
    S_RD_R
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-5:0]   r_line;
  logic [1:0]          r_lane;
  logic [127:0]        r_wdata;
  logic [15:0]         r_wstrb;
  logic                r_aw_done;
  logic                r_w_done;
  logic [31:0]         r_rdata;
  logic                r_valid;
  logic                r_err;

  logic                w_idle;
  logic                w_wr_req;
  logic                w_rd_req;
  logic                w_buf_hit;
  logic                w_acc_wr;
  logic                w_acc_rd;
  logic                w_hit_acc;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_b_hs;
  logic                w_ar_hs;
  logic                w_r_hs;
  logic                w_unused;

  assign w_idle    = (r_state == S_IDLE);
  assign w_wr_req  = |dram_we;
  assign w_rd_req  = dram_oe & ~w_wr_req;
  assign w_acc_wr  = w_idle & w_wr_req;
  assign w_acc_rd  = w_idle & w_rd_req & ~w_buf_hit;
  assign w_hit_acc = w_idle & w_rd_req & w_buf_hit;

  // Handshakes are derived from state directly so they do not loop back
  // through the combinational output block.
  assign w_aw_hs = (r_state == S_WR) & ~r_aw_done & m_axi_awready;
  assign w_w_hs  = (r_state == S_WR) & ~r_w_done  & m_axi_wready;
  assign w_b_hs  = (r_state == S_WRESP) & m_axi_bvalid;
  assign w_ar_hs = (r_state == S_RD_AR) & m_axi_arready;
  assign w_r_hs  = (r_state == S_RD_R)  & m_axi_rvalid;

  assign w_unused = &{1'b0, m_axi_bid, m_axi_rid, m_axi_rlast, dram_addr[1:0]};

`ifdef AXI_MEM_RDBUF_EN
  logic [127:0]      r_buf_line;
  logic [ADDR_W-5:0] r_buf_tag;
  logic              r_buf_vld;

  assign w_buf_hit = r_buf_vld & (r_buf_tag == dram_addr[ADDR_W-1:4]);

  // Read line buffer: fill on a clean R beat, invalidate on a write to the same line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_line <= '0;
      r_buf_tag  <= '0;
      r_buf_vld  <= 1'b0;
    end else if (w_r_hs && (m_axi_rresp == 2'b00)) begin
      r_buf_line <= m_axi_rdata;
      r_buf_tag  <= r_line;
      r_buf_vld  <= 1'b1;
    end else if (w_acc_wr && (r_buf_tag == dram_addr[ADDR_W-1:4])) begin
      r_buf_vld  <= 1'b0;
    end
  end
`else
  assign w_buf_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and channel valid/ready outputs
  always_comb begin
    w_state_nxt   = r_state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr_req) begin
          w_state_nxt = S_WR;
        end else if (w_rd_req && !w_buf_hit) begin
          w_state_nxt = S_RD_AR;
        end
      end
      S_WR: begin
        m_axi_awvalid = ~r_aw_done;
        m_axi_wvalid  = ~r_w_done;
        if ((r_aw_done | m_axi_awready) && (r_w_done | m_axi_wready)) begin
          w_state_nxt = S_WRESP;
        end
      end
      S_WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          w_state_nxt = S_RD_R;
        end
      end
      S_RD_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture: line address, lane, replicated data and shifted strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line  <= '0;
      r_lane  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_acc_wr) begin
      r_line  <= dram_addr[ADDR_W-1:4];
      r_lane  <= dram_addr[3:2];
      r_wdata <= {4{dram_wdata}};
      r_wstrb <= {12'h000, dram_we} << {dram_addr[3:2], 2'b00};
    end else if (w_acc_rd) begin
      r_line  <= dram_addr[ADDR_W-1:4];
      r_lane  <= dram_addr[3:2];
    end
  end

  // AW/W completion flags, cleared when a write is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_acc_wr) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  // Read return: one-cycle valid pulse with the selected 32-bit lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_r_hs) begin
        r_valid <= 1'b1;
        r_rdata <= m_axi_rdata[{r_lane, 5'b00000} +: 32];
      end
`ifdef AXI_MEM_RDBUF_EN
      else if (w_hit_acc) begin
        r_valid <= 1'b1;
        r_rdata <= r_buf_line[{dram_addr[3:2], 5'b00000} +: 32];
      end
`endif
    end
  end

  // Sticky error flag on any non-OKAY write or read response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((w_b_hs && (m_axi_bresp != 2'b00)) || (w_r_hs && (m_axi_rresp != 2'b00))) begin
      r_err <= 1'b1;
    end
  end

  assign dram_rdata = r_rdata;
  assign dram_valid = r_valid;
  assign dram_busy  = ~w_idle;
  assign resp_err   = r_err;

  assign m_axi_awid     = '0;
  assign m_axi_awaddr   = {r_line, 4'h0};
  assign m_axi_awlen    = '0;
  assign m_axi_awsize   = 3'b100;
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'b0011;
  assign m_axi_awprot   = '0;
  assign m_axi_awqos    = '0;
  assign m_axi_awregion = '0;

  assign m_axi_wdata    = r_wdata;
  assign m_axi_wstrb    = r_wstrb;
  assign m_axi_wlast    = 1'b1;

  assign m_axi_arid     = '0;
  assign m_axi_araddr   = {r_line, 4'h0};
  assign m_axi_arlen    = '0;
  assign m_axi_arsize   = 3'b100;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arprot   = '0;
  assign m_axi_arqos    = '0;
  assign m_axi_arregion = '0;

endmodule

// File: tb/tb_axi_mem_master.sv
// Directed self-checking bench for axi_mem_master with a small AXI slave model
// whose ready/valid delays and response codes are set per step.
module tb_axi_mem_master;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              dram_oe = 1'b0;
  logic [ADDR_W-1:0] dram_addr = '0;
  logic [31:0]       dram_wdata = '0;
  logic [3:0]        dram_we = '0;
  logic [31:0]       dram_rdata;
  logic              dram_valid, dram_busy, resp_err;

  logic [0:0]        m_axi_awid, m_axi_arid;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]        m_axi_awlen, m_axi_arlen;
  logic [2:0]        m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]        m_axi_awburst, m_axi_arburst;
  logic              m_axi_awlock, m_axi_arlock;
  logic [3:0]        m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
  logic [3:0]        m_axi_awregion, m_axi_arregion;
  logic              m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [127:0]      m_axi_wdata;
  logic [15:0]       m_axi_wstrb;
  logic              m_axi_wlast;

  // slave model state
  logic              s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]        s_bresp, s_rresp;
  logic [127:0]      s_rdata;
  logic              aw_got, w_got, ar_got;
  logic [31:0]       cap_awaddr, cap_araddr;
  logic [127:0]      cap_wdata;
  logic [15:0]       cap_wstrb;
  int unsigned       aw_cnt, w_cnt, ar_cnt, r_cnt;
  int unsigned       ar_count = 0;
  logic [127:0]      mem [0:4095];
  logic [127:0]      merged;

  // slave configuration, driven by the stimulus
  int unsigned       aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]        b_resp_cfg = 2'b00;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_mem_master #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .dram_oe(dram_oe), .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
    .dram_rdata(dram_rdata), .dram_valid(dram_valid), .dram_busy(dram_busy), .resp_err(resp_err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awregion(m_axi_awregion), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(s_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(s_wready),
    .m_axi_bid(1'b0), .m_axi_bresp(s_bresp), .m_axi_bvalid(s_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(s_arready),
    .m_axi_rid(1'b0), .m_axi_rdata(s_rdata), .m_axi_rresp(s_rresp), .m_axi_rlast(1'b1),
    .m_axi_rvalid(s_rvalid), .m_axi_rready(m_axi_rready)
  );

  // byte-merge of the captured write into the addressed line
  always_comb begin
    merged = mem[cap_awaddr[15:4]];
    for (int i = 0; i < 16; i++) begin
      if (cap_wstrb[i]) merged[8*i +: 8] = cap_wdata[8*i +: 8];
    end
  end

  // AXI slave model; memory lines are preloaded on reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0;
      s_arready <= 1'b0; s_rvalid <= 1'b0;
      s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      cap_awaddr <= '0; cap_araddr <= '0; cap_wdata <= '0; cap_wstrb <= '0;
      mem[12'h010] <= {96'h0, 32'hCAFE0100};
      mem[12'h100] <= {32'h0BADF00D, 96'h0};
      mem[12'h200] <= {64'h0, 32'h11223344, 32'h0};
      mem[12'h300] <= {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    end else begin
      if (m_axi_awvalid && !s_awready && !aw_got) begin
        if (aw_cnt >= aw_dly) s_awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
      end
      if (m_axi_awvalid && s_awready) begin
        aw_got <= 1'b1; cap_awaddr <= m_axi_awaddr; s_awready <= 1'b0; aw_cnt <= 0;
      end
      if (m_axi_wvalid && !s_wready && !w_got) begin
        if (w_cnt >= w_dly) s_wready <= 1'b1; else w_cnt <= w_cnt + 1;
      end
      if (m_axi_wvalid && s_wready) begin
        w_got <= 1'b1; cap_wdata <= m_axi_wdata; cap_wstrb <= m_axi_wstrb;
        s_wready <= 1'b0; w_cnt <= 0;
      end
      if (aw_got && w_got && !s_bvalid) begin
        mem[cap_awaddr[15:4]] <= merged;
        s_bvalid <= 1'b1; s_bresp <= b_resp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (s_bvalid && m_axi_bready) s_bvalid <= 1'b0;

      if (m_axi_arvalid && !s_arready && !ar_got) begin
        if (ar_cnt >= ar_dly) s_arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
      end
      if (m_axi_arvalid && s_arready) begin
        ar_got <= 1'b1; cap_araddr <= m_axi_araddr; s_arready <= 1'b0; ar_cnt <= 0;
        ar_count <= ar_count + 1;
      end
      if (ar_got && !s_rvalid) begin
        if (r_cnt >= r_dly) begin
          s_rvalid <= 1'b1; s_rdata <= mem[cap_araddr[15:4]]; s_rresp <= 2'b00;
          ar_got <= 1'b0; r_cnt <= 0;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
      if (s_rvalid && m_axi_rready) s_rvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one request for one cycle; called and returns at a falling edge
  task automatic issue(input logic oe, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] we);
    dram_oe = oe; dram_addr = addr; dram_wdata = wd; dram_we = we;
    @(negedge clk);
    dram_oe = 1'b0; dram_addr = '0; dram_wdata = '0; dram_we = '0;
  endtask

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (dram_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_valid_seen"}, 128'(ok), 128'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!dram_busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_idle_seen"}, 128'(ok), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a0;
    bit seen;
    int bad_addr, bad_busy;

    // reset state
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 128'(dram_busy), 128'd0);
    chk("rst_valid", 128'(dram_valid), 128'd0);
    chk("rst_rdata", 128'(dram_rdata), 128'd0);
    chk("rst_err", 128'(resp_err), 128'd0);
    chk("rst_awvalid", 128'(m_axi_awvalid), 128'd0);
    chk("rst_arvalid", 128'(m_axi_arvalid), 128'd0);
    rst = 1'b0;

    // reset while waiting in RD_R
    r_dly = 20;
    issue(1'b1, 32'h0000_0100, 32'h0, 4'h0);
    chk("rd_start_arvalid", 128'(m_axi_arvalid), 128'd1);
    chk("rd_start_busy", 128'(dram_busy), 128'd1);
    chk("rd_start_araddr", 128'(m_axi_araddr), 128'h100);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_axi_rready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("rd_r_reached", 128'(seen), 128'd1);
    rst = 1'b1;
    #1;
    chk("midrst_arvalid", 128'(m_axi_arvalid), 128'd0);
    chk("midrst_rready", 128'(m_axi_rready), 128'd0);
    chk("midrst_busy", 128'(dram_busy), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (dram_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", 128'(seen), 128'd0);
    r_dly = 0;
    issue(1'b1, 32'h0000_0100, 32'h0, 4'h0);
    wait_valid("rd100");
    chk("rd100_data", 128'(dram_rdata), 128'hCAFE0100);

    // full-word write, W handshake before AW
    @(negedge clk);
    aw_dly = 2; w_dly = 0;
    issue(1'b0, 32'h0000_1008, 32'hDEADBEEF, 4'hF);
    chk("wr_awvalid", 128'(m_axi_awvalid), 128'd1);
    chk("wr_wvalid", 128'(m_axi_wvalid), 128'd1);
    chk("wr_busy", 128'(dram_busy), 128'd1);
    chk("wr_awaddr", 128'(m_axi_awaddr), 128'h1000);
    chk("wr_wstrb", 128'(m_axi_wstrb), 128'h0F00);
    @(negedge clk);
    @(negedge clk);
    chk("wr_w_first_wvalid", 128'(m_axi_wvalid), 128'd0);
    chk("wr_w_first_awvalid", 128'(m_axi_awvalid), 128'd1);
    wait_idle("wr1008");
    chk("wr_no_valid", 128'(dram_valid), 128'd0);
    chk("wr_cap_awaddr", 128'(cap_awaddr), 128'h1000);
    chk("wr_cap_wstrb", 128'(cap_wstrb), 128'h0F00);
    chk("wr_cap_wdata", cap_wdata, {4{32'hDEADBEEF}});
    aw_dly = 0;
    issue(1'b1, 32'h0000_1008, 32'h0, 4'h0);
    wait_valid("rb1008");
    chk("rb1008_data", 128'(dram_rdata), 128'hDEADBEEF);
    chk("rb1008_busy", 128'(dram_busy), 128'd0);
    @(negedge clk);
    chk("rb1008_pulse", 128'(dram_valid), 128'd0);

    // byte write, AW handshake before W
    w_dly = 3;
    issue(1'b0, 32'h0000_2004, 32'h0000AB00, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    chk("bw_aw_first_awvalid", 128'(m_axi_awvalid), 128'd0);
    chk("bw_aw_first_wvalid", 128'(m_axi_wvalid), 128'd1);
    wait_idle("bw2004");
    chk("bw_cap_wstrb", 128'(cap_wstrb), 128'h0020);
    chk("bw_cap_awaddr", 128'(cap_awaddr), 128'h2000);
    w_dly = 0;
    issue(1'b1, 32'h0000_2004, 32'h0, 4'h0);
    wait_valid("rb2004");
    chk("rb2004_data", 128'(dram_rdata), 128'h1122AB44);

    // backpressure with a dropped mid-flight request
    @(negedge clk);
    ar_dly = 5; r_dly = 7;
    a0 = ar_count;
    issue(1'b1, 32'h0000_100C, 32'h0, 4'h0);
    bad_addr = 0; bad_busy = 0; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (dram_valid) begin seen = 1'b1; break; end
      if (m_axi_arvalid && (m_axi_araddr !== 32'h1000)) bad_addr++;
      if (!dram_busy) bad_busy++;
      if (i == 3) begin dram_oe = 1'b1; dram_addr = 32'h0000_3000; end
      if (i == 4) begin dram_oe = 1'b0; dram_addr = '0; end
      @(negedge clk);
    end
    chk("bp_valid_seen", 128'(seen), 128'd1);
    chk("bp_araddr_stable", 128'(bad_addr), 128'd0);
    chk("bp_busy_held", 128'(bad_busy), 128'd0);
    chk("bp_data", 128'(dram_rdata), 128'h0BADF00D);
    chk("bp_one_ar", 128'(ar_count - a0), 128'd1);
    repeat (5) @(negedge clk);
    chk("bp_no_second_ar", 128'(ar_count - a0), 128'd1);
    chk("bp_idle_after", 128'(dram_busy), 128'd0);
    ar_dly = 0; r_dly = 0;

    // error response on a write
    chk("err_before", 128'(resp_err), 128'd0);
    b_resp_cfg = 2'b10;
    issue(1'b0, 32'h0000_1008, 32'hDEADBEEF, 4'hF);
    wait_idle("errwr");
    chk("err_set", 128'(resp_err), 128'd1);
    b_resp_cfg = 2'b00;
    issue(1'b1, 32'h0000_1008, 32'h0, 4'h0);
    wait_valid("errrd");
    chk("err_rd_data", 128'(dram_rdata), 128'hDEADBEEF);
    chk("err_sticky", 128'(resp_err), 128'd1);

`ifdef AXI_MEM_RDBUF_EN
    // read buffer hit, invalidate, refill
    @(negedge clk);
    a0 = ar_count;
    issue(1'b1, 32'h0000_3000, 32'h0, 4'h0);
    wait_valid("buf_fill");
    chk("buf_fill_data", 128'(dram_rdata), 128'h11111111);
    chk("buf_fill_ar", 128'(ar_count - a0), 128'd1);
    @(negedge clk);
    issue(1'b1, 32'h0000_3004, 32'h0, 4'h0);
    chk("buf_hit_valid", 128'(dram_valid), 128'd1);
    chk("buf_hit_data", 128'(dram_rdata), 128'h22222222);
    chk("buf_hit_busy", 128'(dram_busy), 128'd0);
    chk("buf_hit_arvalid", 128'(m_axi_arvalid), 128'd0);
    @(negedge clk);
    chk("buf_hit_pulse", 128'(dram_valid), 128'd0);
    chk("buf_hit_no_ar", 128'(ar_count - a0), 128'd1);
    issue(1'b0, 32'h0000_300C, 32'h55555555, 4'hF);
    wait_idle("buf_inv_wr");
    issue(1'b1, 32'h0000_3004, 32'h0, 4'h0);
    wait_valid("buf_miss");
    chk("buf_miss_data", 128'(dram_rdata), 128'h22222222);
    chk("buf_miss_ar", 128'(ar_count - a0), 128'd2);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
